alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit add/subtract ALU among NREQ requesters. It latches the winning requester's operands and opcode, drives them to the external combinational ALU, captures the result, and returns it with a one-cycle Done pulse tagged by requester index. It sits between the datapath's ALU instance and its clients: decode units, address generators and similar.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 84 ++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and ALU signal bundle for alu_arbiter
// slave is the arbiter side; master is the requesters plus the external ALU.
interface alu_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       Req;
  logic [NREQ*WIDTH-1:0] ReqA;
  logic [NREQ*WIDTH-1:0] ReqB;
  logic [NREQ-1:0]       ReqOp;
  logic [NREQ-1:0]       Ack;
  logic [WIDTH-1:0]      AluA;
  logic [WIDTH-1:0]      AluB;
  logic                  AluOp;
  logic [WIDTH-1:0]      AluOut;
  logic [WIDTH-1:0]      Result;
  logic                  Zero;
  logic                  Done;
  logic [IDW-1:0]        DoneId;
  logic                  Busy;

  modport slave (
    input  Req, ReqA, ReqB, ReqOp, AluOut,
    output Ack, AluA, AluB, AluOp, Result, Zero, Done, DoneId, Busy
  );

  modport master (
    output Req, ReqA, ReqB, ReqOp, AluOut,
    input  Ack, AluA, AluB, AluOp, Result, Zero, Done, DoneId, Busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one add/sub ALU among NREQ requesters
// Two-state sequencer: IDLE grants and latches operands, EXEC captures the ALU result.
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win;
  logic           found;
  logic [IDW-1:0] ptr_next;
  logic [NREQ-1:0] win_onehot;

  // Rotating search: first set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.Req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign ptr_next   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign bus.Busy   = (state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      bus.Ack    <= '0;
      bus.AluA   <= '0;
      bus.AluB   <= '0;
      bus.AluOp  <= 1'b0;
      bus.Result <= '0;
      bus.Zero   <= 1'b0;
      bus.Done   <= 1'b0;
      bus.DoneId <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.Ack  <= '0;
          bus.Done <= 1'b0;
          if (found) begin
            bus.AluA  <= bus.ReqA[int'(win)*WIDTH +: WIDTH];
            bus.AluB  <= bus.ReqB[int'(win)*WIDTH +: WIDTH];
            bus.AluOp <= bus.ReqOp[win];
            id        <= win;
            bus.Ack   <= win_onehot;
            ptr       <= ptr_next;
            state     <= EXEC;
          end
        end
        default: begin
          // Requests are ignored here; the ALU output is settled from the latched operands.
          bus.Result <= bus.AluOut;
          bus.Zero   <= (bus.AluOut == '0);
          bus.Done   <= 1'b1;
          bus.DoneId <= id;
          bus.Ack    <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// Directed scenarios followed by random traffic, compared against a cycle reference model.
module tb_alu_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   drop_on_ack;

  alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external combinational ALU.
  always_comb bus.AluOut = bus.AluOp ? (bus.AluA - bus.AluB) : (bus.AluA + bus.AluB);

  // Reference model state
  logic            m_exec;
  int              m_ptr;
  int              m_id;
  logic [WIDTH-1:0] m_a, m_b, m_result;
  logic            m_op, m_zero, m_done;
  logic [NREQ-1:0] m_ack;
  int              m_doneid;

  task automatic model_reset();
    m_exec = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; m_op = 0;
    m_result = '0; m_zero = 0; m_done = 0; m_ack = '0; m_doneid = 0;
  endtask

  task automatic model_step();
    int w;
    if (!m_exec) begin
      m_done = 0;
      m_ack  = '0;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.Req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_a    = bus.ReqA[w*WIDTH +: WIDTH];
        m_b    = bus.ReqB[w*WIDTH +: WIDTH];
        m_op   = bus.ReqOp[w];
        m_id   = w;
        m_ack  = NREQ'(1) << w;
        m_ptr  = (w + 1) % NREQ;
        m_exec = 1;
      end
    end else begin
      m_result = m_op ? WIDTH'(int'(m_a) - int'(m_b)) : WIDTH'(int'(m_a) + int'(m_b));
      m_zero   = (m_result == 0);
      m_done   = 1;
      m_doneid = m_id;
      m_ack    = '0;
      m_exec   = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".ack"},    32'(bus.Ack),    32'(m_ack));
    chk({ph, ".done"},   32'(bus.Done),   32'(m_done));
    chk({ph, ".busy"},   32'(bus.Busy),   32'(m_exec));
    chk({ph, ".alua"},   32'(bus.AluA),   32'(m_a));
    chk({ph, ".alub"},   32'(bus.AluB),   32'(m_b));
    chk({ph, ".aluop"},  32'(bus.AluOp),  32'(m_op));
    chk({ph, ".result"}, 32'(bus.Result), 32'(m_result));
    chk({ph, ".zero"},   32'(bus.Zero),   32'(m_zero));
    chk({ph, ".doneid"}, 32'(bus.DoneId), 32'(m_doneid));
  endtask

  // Inputs change at negedge; one call covers one rising edge plus the checks after it.
  task automatic cycle(input string ph);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
    if (drop_on_ack) bus.Req = bus.Req & ~m_ack;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic op);
    bus.ReqA[i*WIDTH +: WIDTH] = a;
    bus.ReqB[i*WIDTH +: WIDTH] = b;
    bus.ReqOp[i] = op;
  endtask

  initial begin
    int q_ack[$];
    int q_done[$];
    int exp_ack[4];
    int ndone;

    rst_n = 1'b0;
    bus.Req = '0; bus.ReqA = '0; bus.ReqB = '0; bus.ReqOp = '0;
    drop_on_ack = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Single add
    set_op(0, 16'h1234, 16'h0011, 1'b0);
    bus.Req = 4'b0001;
    cycle("add1");
    chk("add_ack", 32'(bus.Ack), 32'h1);
    cycle("add2");
    chk("add_result", 32'(bus.Result), 32'h1245);
    chk("add_done", 32'(bus.Done), 32'h1);
    chk("add_zero", 32'(bus.Zero), 32'h0);
    chk("add_doneid", 32'(bus.DoneId), 32'h0);

    // Subtract wrap and zero on requester 2
    set_op(2, 16'h0000, 16'h0001, 1'b1);
    bus.Req = 4'b0100;
    cycle("sub1"); cycle("sub1b");
    chk("sub_wrap_result", 32'(bus.Result), 32'hFFFF);
    chk("sub_wrap_zero", 32'(bus.Zero), 32'h0);
    chk("sub_wrap_id", 32'(bus.DoneId), 32'h2);
    set_op(2, 16'h0005, 16'h0005, 1'b1);
    bus.Req = 4'b0100;
    cycle("sub2"); cycle("sub2b");
    chk("sub_zero_result", 32'(bus.Result), 32'h0);
    chk("sub_zero_zero", 32'(bus.Zero), 32'h1);

    // Full contention from a fresh reset
    @(negedge clk);
    rst_n = 1'b0; #1; model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(16'h0100 * i), WIDTH'(i + 1), 1'b0);
    bus.Req = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      cycle("contend");
      if (bus.Ack != 0) q_ack.push_back(int'(bus.Ack));
      if (bus.Done) begin
        q_done.push_back(c);
        chk("contend_doneid", 32'(bus.DoneId), 32'((q_done.size() - 1)));
      end
    end
    exp_ack = '{1, 2, 4, 8};
    chk("contend_nack", 32'(q_ack.size()), 32'd4);
    chk("contend_ndone", 32'(q_done.size()), 32'd4);
    for (int i = 0; i < q_ack.size() && i < 4; i++) chk("contend_ack_order", 32'(q_ack[i]), 32'(exp_ack[i]));
    for (int i = 0; i < q_done.size() && i < 4; i++) chk("contend_done_cycle", 32'(q_done[i]), 32'(2 * (i + 1)));

    // Rotation fairness: after requester 2, 1010 grants 3 then 1
    bus.Req = 4'b0100;
    cycle("rot_a"); cycle("rot_b");
    q_ack.delete();
    bus.Req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      cycle("rot");
      if (bus.Ack != 0) q_ack.push_back(int'(bus.Ack));
    end
    chk("rot_nack", 32'(q_ack.size()), 32'd2);
    if (q_ack.size() == 2) begin
      chk("rot_first", 32'(q_ack[0]), 32'h8);
      chk("rot_second", 32'(q_ack[1]), 32'h2);
    end

    // Reset during EXEC
    bus.Req = 4'b0001;
    cycle("rst_mid_grant");
    chk("rst_mid_busy_before", 32'(bus.Busy), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.Req = '0;
    cycle("rst_mid_after");
    chk("rst_mid_no_done", 32'(bus.Done), 32'h0);
    bus.Req = 4'b1111;
    cycle("rst_regrant");
    chk("rst_regrant_ack", 32'(bus.Ack), 32'h1);
    bus.Req = '0;
    cycle("rst_regrant_done");

    // Held request on requester 1 for six cycles
    drop_on_ack = 0;
    set_op(1, 16'h7FFF, 16'h0001, 1'b0);
    bus.Req = 4'b0010;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      cycle("held");
      chk("held_busy", 32'(bus.Busy), 32'((c % 2) == 0));
      if (bus.Done) ndone++;
    end
    chk("held_ndone", 32'(ndone), 32'd3);
    chk("held_result", 32'(bus.Result), 32'h8000);
    bus.Req = '0;
    cycle("held_idle");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drop_on_ack = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NREQ; i++) begin
        logic [WIDTH-1:0] a;
        a = WIDTH'($urandom);
        set_op(i, a, ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 2) != 0) bus.Req = NREQ'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
